// File: rtl/onflight_pkg.sv
// Shared constants and request record for the on-flight SRAM arbiter.
// The arbiter's request record widths follow AW and DW below.
package onflight_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 256;
  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/onflight_rr_pick.sv
// Round-robin picker: returns the first eligible index in scan order from ptr and the
// next eligible index after it that is not masked.
module onflight_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  first,
  output logic          first_valid,
  output logic [N-1:0]  second,
  output logic          second_valid
);

  logic [PW-1:0] idx_a;
  logic [PW-1:0] idx_b;

  always_comb begin : p_first
    first       = '0;
    first_valid = 1'b0;
    idx_a       = ptr;
    for (int k = 0; k < int'(N); k++) begin
      idx_a = ptr + PW'(k);
      if (!first_valid && elig[idx_a]) begin
        first[idx_a] = 1'b1;
        first_valid  = 1'b1;
      end
    end
  end

  // Kept separate from p_first: mask may be derived from the first pick.
  always_comb begin : p_second
    second       = '0;
    second_valid = 1'b0;
    idx_b        = ptr;
    for (int k = 0; k < int'(N); k++) begin
      idx_b = ptr + PW'(k);
      if (!second_valid && elig[idx_b] && !first[idx_b] && !mask[idx_b]) begin
        second[idx_b] = 1'b1;
        second_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onflight_sram_arbiter.sv
// Arbitrates NREQ requesters onto the two-read/two-write on-flight SRAM and returns
// registered, per-requester read data one cycle after the grant.
module onflight_sram_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rd_valid,
  output logic [NREQ*DW-1:0] rd_data,
  output logic               sram_WE,
  output logic [AW-1:0]      sram_WriteAddress1,
  output logic [AW-1:0]      sram_WriteAddress2,
  output logic [AW-1:0]      sram_ReadAddress1,
  output logic [AW-1:0]      sram_ReadAddress2,
  output logic [DW-1:0]      sram_WriteBus1,
  output logic [DW-1:0]      sram_WriteBus2,
  input  logic [DW-1:0]      sram_ReadBus1,
  input  logic [DW-1:0]      sram_ReadBus2
);

  import onflight_pkg::*;

  localparam int unsigned PW = $clog2(NREQ);

  req_t            reqs [NREQ];
  logic [NREQ-1:0] elig_rd, elig_wr, wr_conflict;
  logic [NREQ-1:0] rd_first, rd_second, wr_first, wr_second;
  logic            rd_first_v, rd_second_v, wr_first_v, wr_second_v;
  logic [PW-1:0]   rr_ptr, rr_ptr_next, scan_idx;
  logic [AW-1:0]   wr_addr1, wr_addr2, rd_addr1, rd_addr2;
  logic [DW-1:0]   wr_data1, wr_data2;

  // Reset masks eligibility so grants, WE and all SRAM pins fall to idle together.
  always_comb begin : p_unpack
    for (int i = 0; i < int'(NREQ); i++) begin
      reqs[i].we    = req_we[i];
      reqs[i].addr  = req_addr[i*AW +: AW];
      reqs[i].wdata = req_wdata[i*DW +: DW];
      elig_rd[i]    = req[i] & ~reqs[i].we & ~reset;
      elig_wr[i]    = req[i] & reqs[i].we & ~reset;
    end
  end

  onflight_rr_pick #(
    .N (NREQ),
    .PW(PW)
  ) u_rd_pick (
    .elig        (elig_rd),
    .ptr         (rr_ptr),
    .mask        ('0),
    .first       (rd_first),
    .first_valid (rd_first_v),
    .second      (rd_second),
    .second_valid(rd_second_v)
  );

  onflight_rr_pick #(
    .N (NREQ),
    .PW(PW)
  ) u_wr_pick (
    .elig        (elig_wr),
    .ptr         (rr_ptr),
    .mask        (wr_conflict),
    .first       (wr_first),
    .first_valid (wr_first_v),
    .second      (wr_second),
    .second_valid(wr_second_v)
  );

  always_comb begin : p_wr_port1
    wr_addr1 = '0;
    wr_data1 = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (wr_first[i]) begin
        wr_addr1 = reqs[i].addr;
        wr_data1 = reqs[i].wdata;
      end
    end
  end

  // Two writes to one address in a cycle would race on the shared WE, so block them.
  always_comb begin : p_wr_conflict
    for (int i = 0; i < int'(NREQ); i++) begin
      wr_conflict[i] = (reqs[i].addr == wr_addr1);
    end
  end

  always_comb begin : p_wr_port2
    wr_addr2 = '0;
    wr_data2 = '0;
    if (wr_second_v) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (wr_second[i]) begin
          wr_addr2 = reqs[i].addr;
          wr_data2 = reqs[i].wdata;
        end
      end
    end else if (wr_first_v) begin
      wr_addr2 = wr_addr1;
      wr_data2 = wr_data1;
    end
  end

  always_comb begin : p_rd_ports
    rd_addr1 = '0;
    rd_addr2 = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (rd_first_v && rd_first[i]) begin
        rd_addr1 = reqs[i].addr;
      end
      if (rd_second_v && rd_second[i]) begin
        rd_addr2 = reqs[i].addr;
      end
    end
  end

  assign gnt                = rd_first | rd_second | wr_first | wr_second;
  assign sram_WE            = wr_first_v;
  assign sram_WriteAddress1 = wr_addr1;
  assign sram_WriteAddress2 = wr_addr2;
  assign sram_WriteBus1     = wr_data1;
  assign sram_WriteBus2     = wr_data2;
  assign sram_ReadAddress1  = rd_addr1;
  assign sram_ReadAddress2  = rd_addr2;

  // Pointer moves just past the last granted index in scan order, reads and writes alike.
  always_comb begin : p_ptr_next
    rr_ptr_next = rr_ptr;
    scan_idx    = rr_ptr;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan_idx = rr_ptr + PW'(k);
      if (gnt[scan_idx]) begin
        rr_ptr_next = scan_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin : p_state
    if (reset) begin
      rr_ptr   <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rr_ptr   <= rr_ptr_next;
      rd_valid <= rd_first | rd_second;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (rd_first[i]) begin
          rd_data[i*DW +: DW] <= sram_ReadBus1;
        end else if (rd_second[i]) begin
          rd_data[i*DW +: DW] <= sram_ReadBus2;
        end
      end
    end
  end

endmodule
